// File: rtl/img_seq_ctrl.sv
// Raster address generator and digit-image sequencer for the 3/5/9 ROM bank.
// Image selection (manual switches or timed auto-cycle) only changes at frame start.
module img_seq_ctrl #(
   parameter int IMG_W        = 640,
   parameter int IMG_H        = 480,
   parameter int ADDR_W       = 19,
   parameter int DWELL_FRAMES = 128
) (
   input  logic              VGA_CTRL_CLK,
   input  logic              DLY_RST_2,
   input  logic              iVGA_REQ,
   input  logic              iVSYNC_N,
   input  logic              iAUTO,
   input  logic              iNEXT_N,
   input  logic [2:0]        iMAN_SEL,
   output logic [ADDR_W-1:0] oADDR,
   output logic [2:0]        oSEL,
   output logic [3:0]        oDIGIT,
   output logic              oPIX_VALID,
   output logic              state_dbg
);

   localparam logic [ADDR_W-1:0] IMG_LAST   = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [7:0]        DWELL_LAST = 8'(DWELL_FRAMES - 1);

   typedef enum logic {S_MAN = 1'b0, S_AUTO = 1'b1} state_t;

   state_t     state;
   logic [7:0] dwell;
   logic [1:0] pend_idx;
   logic [1:0] disp_idx;
   logic       adv_req;
   logic       auto_s1, auto_s2;
   logic       next_s1, next_s2, next_s3;
   logic       vsync_d;
   logic       req_d1, req_d2;
   logic       frame_start, next_pulse, advance;
   logic [1:0] man_idx, show_idx;

   function automatic logic [1:0] idx_inc(input logic [1:0] idx);
      case (idx)
         2'd0:    idx_inc = 2'd1;
         2'd1:    idx_inc = 2'd2;
         2'd3:    idx_inc = 2'd1;
         default: idx_inc = 2'd0;
      endcase
   endfunction

   function automatic logic [2:0] sel_of(input logic [1:0] idx);
      case (idx)
         2'd1:    sel_of = 3'b010;
         2'd2:    sel_of = 3'b100;
         default: sel_of = 3'b001;
      endcase
   endfunction

   function automatic logic [3:0] digit_of(input logic [1:0] idx);
      case (idx)
         2'd1:    digit_of = 4'd5;
         2'd2:    digit_of = 4'd9;
         default: digit_of = 4'd3;
      endcase
   endfunction

   assign frame_start = ~iVSYNC_N & vsync_d;
   assign next_pulse  = next_s3 & ~next_s2;
   assign oPIX_VALID  = req_d2;
   assign state_dbg   = (state == S_AUTO);

   always_comb begin
      case (iMAN_SEL)
         3'b010, 3'b011:         man_idx = 2'd1;
         3'b100, 3'b110, 3'b111: man_idx = 2'd2;
         default:                man_idx = 2'd0;
      endcase
   end

   // show_idx is what the display switches to if this cycle is a frame start.
   always_comb begin
      advance  = (state == S_AUTO) && frame_start && (adv_req || dwell == DWELL_LAST);
      show_idx = pend_idx;
      if (state == S_MAN)
         show_idx = man_idx;
      else if (advance)
         show_idx = idx_inc(pend_idx);
   end

   always_ff @(posedge VGA_CTRL_CLK or posedge DLY_RST_2) begin
      if (DLY_RST_2) begin
         auto_s1 <= 1'b0;
         auto_s2 <= 1'b0;
         next_s1 <= 1'b1;
         next_s2 <= 1'b1;
         next_s3 <= 1'b1;
         vsync_d <= 1'b0;
         req_d1  <= 1'b0;
         req_d2  <= 1'b0;
         oADDR   <= '0;
      end else begin
         auto_s1 <= iAUTO;
         auto_s2 <= auto_s1;
         next_s1 <= iNEXT_N;
         next_s2 <= next_s1;
         next_s3 <= next_s2;
         vsync_d <= iVSYNC_N;
         req_d1  <= iVGA_REQ;
         req_d2  <= req_d1;
         if (frame_start)
            oADDR <= '0;
         else if (iVGA_REQ)
            oADDR <= (oADDR == IMG_LAST) ? '0 : oADDR + 1'b1;
      end
   end

   always_ff @(posedge VGA_CTRL_CLK or posedge DLY_RST_2) begin
      if (DLY_RST_2) begin
         state    <= S_MAN;
         dwell    <= '0;
         pend_idx <= 2'd0;
         disp_idx <= 2'd0;
         adv_req  <= 1'b0;
         oSEL     <= 3'b001;
         oDIGIT   <= 4'd3;
      end else begin
         if (frame_start) begin
            disp_idx <= show_idx;
            oSEL     <= sel_of(show_idx);
            oDIGIT   <= digit_of(show_idx);
         end
         case (state)
            S_MAN: begin
               adv_req  <= 1'b0;
               pend_idx <= man_idx;
               if (auto_s2) begin
                  state    <= S_AUTO;
                  dwell    <= '0;
                  pend_idx <= frame_start ? show_idx : disp_idx;
               end
            end
            default: begin
               // A press landing on the frame-start cycle counts toward the following frame.
               if (frame_start) begin
                  pend_idx <= show_idx;
                  adv_req  <= next_pulse;
                  dwell    <= advance ? 8'd0 : dwell + 8'd1;
               end else if (next_pulse) begin
                  adv_req <= 1'b1;
               end
               if (!auto_s2)
                  state <= S_MAN;
            end
         endcase
      end
   end

endmodule

// File: doc/img_seq_ctrl.md
Name: img_seq_ctrl

Overview:
- Sequencer and address generator for the binary digit image source (the digit 3/5/9 ROM bank with a one-hot SEL input and a 19-bit ADDR input).
- Generates the raster-order ROM address from the VGA pixel request stream.
- Chooses which digit image to show, either from the switches (manual) or by cycling automatically every DWELL_FRAMES frames.
- The selection changes only at frame boundaries, so a frame is never split between two images.

Parameters:
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame; the address wraps at IMG_W*IMG_H-1.
- ADDR_W, 19, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DWELL_FRAMES, 128, number of frames each digit is shown in auto mode (range 1..256).

Ports:
- VGA_CTRL_CLK  in  1  VGA pixel clock; the only clock.
- DLY_RST_2  in  1  asynchronous, active-high reset.
- iVGA_REQ  in  1  pixel request from the VGA controller; one ROM read per high cycle.
- iVSYNC_N  in  1  vertical sync, active low, synchronous to VGA_CTRL_CLK.
- iAUTO  in  1  1 = auto-cycle mode, 0 = manual mode; comes from a switch and is asynchronous.
- iNEXT_N  in  1  "advance" pushbutton, active low, asynchronous.
- iMAN_SEL  in  3  manual selection switches.
- oADDR  out  ADDR_W  ROM address.
- oSEL  out  3  one-hot image select to the image source: 001 = digit 3, 010 = digit 5, 100 = digit 9.
- oDIGIT  out  4  binary value of the displayed digit (3, 5 or 9), for the HEX display.
- oPIX_VALID  out  1  high when ROM data for a requested pixel is valid; equals iVGA_REQ delayed 2 cycles.

Behaviour:
- Reset (asynchronous, while DLY_RST_2 = 1):
  - oADDR = 0, oSEL = 001, oDIGIT = 3, oPIX_VALID = 0.
  - State = S_MAN, dwell counter = 0, pending index = digit 3.
  - All synchronizer and edge registers cleared; the button registers reset to the released level (1).
- Input conditioning:
  - iAUTO and iNEXT_N each pass through a 2-flop synchronizer.
  - next_pulse is a one-cycle pulse on the synchronized falling edge of iNEXT_N: 3 cycles after the pin falls.
  - frame_start is a one-cycle pulse in the cycle where iVSYNC_N = 0 and its value one cycle earlier was 1. No synchronizer on iVSYNC_N (same clock domain).
- Address counter:
  - At the edge ending a frame_start cycle, oADDR <= 0. frame_start has priority over iVGA_REQ in the same cycle; that request does not advance the address.
  - Otherwise, at the edge ending an iVGA_REQ = 1 cycle: oADDR <= oADDR + 1, or 0 if oADDR = IMG_W*IMG_H-1 (wrap).
  - Without iVGA_REQ, oADDR holds.
- oPIX_VALID is a 2-stage delay of iVGA_REQ: one stage for the address register, one for the ROM output register.
- Selection index: a 2-bit register, 0 = digit 3, 1 = digit 5, 2 = digit 9. The value 3 is never reached; if it occurs, it is treated as 0.
- Manual decode of iMAN_SEL (the pending index in S_MAN follows this continuously):
  - 001, 000, 101 → digit 3.
  - 010, 011 → digit 5.
  - 100, 110, 111 → digit 9.
- State machine (state register updates every cycle from synchronized iAUTO):
  - S_MAN → S_AUTO when synced iAUTO = 1; dwell counter cleared, pending index = currently displayed index.
  - S_AUTO → S_MAN when synced iAUTO = 0.
- S_AUTO:
  - At each frame_start, the dwell counter increments.
  - When it reaches DWELL_FRAMES-1 at a frame_start, the pending index advances 3→5→9→3 and the counter clears; this advance takes effect on that same frame_start.
  - A next_pulse sets an advance_req flag. At the next frame_start the index advances by exactly one and the dwell counter clears, regardless of its count.
  - A dwell expiry and advance_req in the same frame advance the index by one only.
  - A second press before that frame_start is absorbed.
- S_MAN: next_pulse is ignored and advance_req is cleared.
- Output update: oSEL and oDIGIT take the pending index only at the edge ending a frame_start cycle, never mid-frame.
- Reset mid-frame: all outputs return to their reset values immediately. After release, the display resumes with digit 3 at the next frame.

Test Plan:
- Reset, then 1 frame with iVSYNC_N pulse and 307200 iVGA_REQ cycles → oADDR steps 0..307199 and wraps to 0; oPIX_VALID = iVGA_REQ delayed 2 cycles.
- Manual mode, iMAN_SEL = 011 mid-frame → oSEL stays 001 until the edge after iVSYNC_N falls, then 010 and oDIGIT = 5; with iMAN_SEL = 111 → 100, oDIGIT = 9; with 101 → 001, oDIGIT = 3.
- iAUTO = 1, DWELL_FRAMES = 4, 12 frames → oDIGIT sequence 3,3,3,3,5,5,5,5,9,9,9,9 and then 3; changes coincide with oADDR clearing to 0.
- Auto mode, two iNEXT_N presses within one frame → exactly one advance, at the next frame_start; dwell restarts (next auto advance 4 frames later). Same presses in manual mode → no change.
- frame_start coinciding with iVGA_REQ = 1 at oADDR = 100 → oADDR = 0 next cycle, not 1.
- Assert DLY_RST_2 mid-frame with oSEL = 100, oADDR = 5000 → oSEL = 001, oADDR = 0, oDIGIT = 3, oPIX_VALID = 0 immediately, without waiting for a clock edge.
